fir_ntap_avg_pipe: RTL and testbench
====================================

// Module: fir_ntap_avg_pipe
// PURPOSE
//  Parametrised successor to the 4-tap signed averaging FIR: an N-tap, W-bit signed boxcar
//  (sum or rounded average) filter with valid handshake, a pipelined adder tree, window-fill
//  tracking and synchronous clear. It sits between a sample source and downstream DSP; the
//  window advances only on accepted samples, so the input stream may have gaps.
// PARAMETERS
//  W     16  signed two's-complement input sample width (>=2)
//  TAPS  4   window length; power of two, 2..64; LG = $clog2(TAPS), OW = W+LG
// PORTS
//  clk         in   1      rising-edge clock
//  reset       in   1      synchronous, active-high reset
//  clear       in   1      sync flush of window, fill count and in-flight results
//  in_valid    in   1      in_data is accepted on this edge
//  in_data     in   W      signed sample
//  avg_mode    in   1      0: out = sum; 1: out = rounded sum/TAPS; sampled with in_data
//  out_valid   out  1      out_data valid this cycle (single-cycle per accepted sample)
//  out_data    out  OW     signed result, sign-extended in avg mode
//  window_full out  1      TAPS samples accepted since last reset/clear
// BEHAVIOUR
//  - Reset (and clear) on an edge: tap[0..TAPS-1]=0, fill count=0, all tree stages and valid
//    pipe=0, out_valid=0, out_data=0, window_full=0. reset has priority over clear; clear
//    has priority over in_valid in the same cycle (sample discarded).
//  - Delay line: on an edge with in_valid=1, tap[0]<=in_data, tap[i]<=tap[i-1]; the taps hold
//    when in_valid=0. tap[0] is the input pipe register (one register delay).
//  - Fill counter: increments on each accepted sample, saturates at TAPS; window_full=1 when
//    count==TAPS (registered; high from the edge that accepts the TAPS-th sample).
//  - Adder tree: LG register levels. Level j adds pairs from level j-1, width W+j, sign
//    extended, exact (no overflow possible). The tree advances every cycle regardless of
//    in_valid. A valid/mode sideband pipe of depth LG travels with it.
//  - Tree input tag: valid = (accepted on previous edge) AND (count was TAPS after that edge).
//    Partial windows never produce out_valid. Zeros in the taps still enter the tree.
//  - Latency: a sample accepted at edge k yields out_valid=1 and out_data after edge k+LG.
//    Output is registered. Throughput is one result per cycle for back-to-back valids.
//  - Sum mode: out_data = sum of tap[0..TAPS-1] (OW bits, exact).
//  - Avg mode: out_data = (sum + 2**(LG-1)) >>> LG (round half toward +inf), computed in
//    OW+1 bits, then sign-extended to OW. The result always fits in W bits.
//  - avg_mode is captured per sample and carried in the sideband. Changing it mid-stream
//    affects only the results for later samples.
//  - clear or reset mid-operation kills every in-flight result: no out_valid is emitted for
//    samples accepted before it. The refill then needs TAPS new samples.
//  - When out_valid=0, out_data holds its last value (no reset-value toggling required).
// TESTING (W=16, TAPS=4 unless noted; LG=2, OW=18)
//  1 reset, then 1,2,3,4 back-to-back, avg_mode=0 -> out_valid only for the 4th sample,
//    2 cycles after its accept edge, out_data=10. window_full rises on the 4th accept.
//  2 same stream, avg_mode=1 -> out_data=3 (10/4=2.5 rounds up). Then -1,-1,-1,-2 with
//    avg_mode=1 -> final out_data=-1 (-5/4 rounds to -1); sum mode gives -5 (0x3FFFB).
//  3 extremes: 4x 0x7FFF sum -> 0x1FFFC. 4x 0x8000 sum -> 0x20000 (-131072); avg -> -32768.
//  4 gaps: 5,6,7 valid, then 3 idle cycles, then 8 -> single out_valid with sum 26. Taps
//    unchanged during the gap; no extra out_valid.
//  5 clear asserted 1 cycle after a full-window sample is accepted -> its result is
//    suppressed, window_full=0, and the next 3 samples give no out_valid. The 4th gives the
//    sum of the post-clear samples only. Repeat with reset mid-stream: identical outcome.
//  6 random 200-sample stream, random in_valid/avg_mode, TAPS=8 and W=24 -> every output
//    matches a behavioural model (window sum or rounded average), with exact valid timing.

Source files
------------

// File: rtl/fir_ntap_avg_pipe.sv
// N-tap signed boxcar filter: window sum or rounded average, pipelined
// adder tree, valid handshake, window-fill tracking and synchronous clear.
// Ports:
//   clk, reset (sync, active-high), clear (sync flush)
//   in_valid/in_data/avg_mode : sample input; mode travels with the sample
//   out_valid/out_data        : one registered result per full-window sample
//   window_full               : TAPS samples accepted since reset/clear
module fir_ntap_avg_pipe #(
   parameter int W    = 16,
   parameter int TAPS = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             clear,
   input  logic                             in_valid,
   input  logic signed [W-1:0]              in_data,
   input  logic                             avg_mode,
   output logic                             out_valid,
   output logic signed [W+$clog2(TAPS)-1:0] out_data,
   output logic                             window_full
);

   localparam int LG   = $clog2(TAPS);
   localparam int OW   = W + LG;
   localparam int NR   = (LG > 1) ? LG - 1 : 1;
   localparam int HALF = 1 << (LG - 1);
   localparam logic [LG:0] FULLCNT = (LG+1)'(TAPS);

   logic signed [W-1:0]  tap_q [TAPS];
   logic [LG:0]          cnt_q, cnt_d;
   logic                 full_q, full_d;
   logic                 acc_q, mode_q;
   // node_q[j-1] holds tree level j (levels 1..LG-1); level LG is out_q
   logic signed [OW-1:0] node_q [NR][TAPS];
   logic signed [OW-1:0] lvl [LG][TAPS];
   logic [LG-1:0]        v_q, vin;
   logic [NR-1:0]        m_q;
   logic [LG-1:0]        mt;
   logic signed [OW-1:0] sum_w, out_q, out_d;
   logic signed [OW:0]   rnd_w;

   always_comb begin
      cnt_d = cnt_q;
      if (in_valid && cnt_q != FULLCNT)
         cnt_d = cnt_q + (LG+1)'(1);
      full_d = (cnt_d == FULLCNT);

      for (int i = 0; i < TAPS; i++)
         lvl[0][i] = {{LG{tap_q[i][W-1]}}, tap_q[i]};
      for (int j = 1; j < LG; j++)
         for (int i = 0; i < TAPS; i++)
            lvl[j][i] = node_q[j-1][i];

      // tag enters with the taps: only a sample that completed a window
      vin[0] = acc_q & full_q;
      mt[0]  = mode_q;
      for (int j = 1; j < LG; j++) begin
         vin[j] = v_q[j-1];
         mt[j]  = m_q[j-1];
      end

      sum_w = lvl[LG-1][0] + lvl[LG-1][1];
      // one extra bit so the rounding offset cannot wrap
      rnd_w = {sum_w[OW-1], sum_w} + (OW+1)'(HALF);
      out_d = mt[LG-1] ? OW'(rnd_w >>> LG) : sum_w;
   end

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         tap_q  <= '{default: '0};
         node_q <= '{default: '0};
         cnt_q  <= '0;
         full_q <= 1'b0;
         acc_q  <= 1'b0;
         mode_q <= 1'b0;
         v_q    <= '0;
         m_q    <= '0;
         out_q  <= '0;
      end else begin
         if (in_valid) begin
            tap_q[0] <= in_data;
            for (int i = 1; i < TAPS; i++)
               tap_q[i] <= tap_q[i-1];
            mode_q <= avg_mode;
         end
         acc_q  <= in_valid;
         cnt_q  <= cnt_d;
         full_q <= full_d;
         for (int j = 1; j < LG; j++)
            for (int i = 0; i < (TAPS >> j); i++)
               node_q[j-1][i] <= lvl[j-1][2*i] + lvl[j-1][2*i+1];
         v_q <= vin;
         for (int j = 1; j < LG; j++)
            m_q[j-1] <= mt[j-1];
         // result register holds its value between valid outputs
         if (vin[LG-1])
            out_q <= out_d;
      end
   end

   assign out_valid   = v_q[LG-1];
   assign out_data    = out_q;
   assign window_full = full_q;

endmodule

// File: tb/tb_fir_ntap_avg_pipe.sv
// Bench for fir_ntap_avg_pipe: directed cases on a 16-bit/4-tap instance,
// randomized stream on a 24-bit/8-tap instance, both against a window model.
module tb_fir_ntap_avg_pipe;

   logic        clk, rst, clr, v4, v8, mode;
   logic [23:0] din;
   logic        ov4, ov8, wf4, wf8;
   logic [17:0] od4;
   logic [26:0] od8;

   fir_ntap_avg_pipe #(.W(16), .TAPS(4)) u4 (
      .clk(clk), .reset(rst), .clear(clr), .in_valid(v4),
      .in_data(din[15:0]), .avg_mode(mode), .out_valid(ov4),
      .out_data(od4), .window_full(wf4)
   );

   fir_ntap_avg_pipe #(.W(24), .TAPS(8)) u8 (
      .clk(clk), .reset(rst), .clear(clr), .in_valid(v8),
      .in_data(din), .avg_mode(mode), .out_valid(ov8),
      .out_data(od8), .window_full(wf8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int        checks = 0;
   int        errors = 0;
   int        cyc = 0;
   int        T, LGv, OWv;
   bit        sel;
   longint    win[$];
   longint    pend[int];
   longint    last, obs;

   task automatic chk(input string tag, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic longint msk();
      return longint'((64'd1 << OWv) - 64'd1);
   endfunction

   // window sum, or floor((sum + T/2) / T) done with plain integer division
   function automatic longint model(input bit m);
      longint s, num, q;
      s = 0;
      foreach (win[i]) s += win[i];
      if (!m) return s;
      num = s + T / 2;
      q = num / T;
      if (num < 0 && (num % T) != 0) q = q - 1;
      return q;
   endfunction

   task automatic step(input bit v, input longint d, input bit m,
                       input bit c, input bit r);
      bit ov, of, ev;
      rst = r; clr = c; mode = m;
      v4 = v & !sel; v8 = v & sel;
      din = d[23:0];
      @(posedge clk);
      cyc++;
      if (r || c) begin
         win.delete();
         pend.delete();
         last = 0;
      end else if (v) begin
         win.push_back(d);
         if (win.size() > T) void'(win.pop_front());
         if (win.size() == T) pend[cyc + LGv] = model(m) & msk();
      end
      #1;
      ov  = sel ? ov8 : ov4;
      of  = sel ? wf8 : wf4;
      obs = sel ? longint'(od8) : longint'(od4);
      ev  = pend.exists(cyc);
      chk("out_valid", longint'(ov), longint'(ev));
      if (ev) begin
         chk("out_data", obs, pend[cyc]);
         last = pend[cyc];
         pend.delete(cyc);
      end else begin
         chk("out_hold", obs, last);
      end
      chk("window_full", longint'(of), longint'(win.size() == T));
      rst = 0; clr = 0; v4 = 0; v8 = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
   endtask

   task automatic feed4(input longint a, input longint b, input longint c,
                        input longint d, input bit m);
      step(1, a, m, 0, 0);
      step(1, b, m, 0, 0);
      step(1, c, m, 0, 0);
      step(1, d, m, 0, 0);
   endtask

   initial begin
      int n, it, r;
      longint d;
      bit v, c;
      rst = 0; clr = 0; v4 = 0; v8 = 0; mode = 0; din = '0;
      last = 0; obs = 0;
      sel = 0; T = 4; LGv = 2; OWv = 18;

      // reset state and basic sum
      step(0, 0, 0, 0, 1);
      feed4(1, 2, 3, 4, 0);
      idle(2);
      chk("t1_sum", obs, 10);

      // rounded average, positive and negative
      step(0, 0, 0, 0, 1);
      feed4(1, 2, 3, 4, 1);
      idle(2);
      chk("t2_avg", obs, 3);
      feed4(-1, -1, -1, -2, 1);
      idle(2);
      chk("t2_avg_neg", obs, (-1) & msk());
      step(0, 0, 0, 0, 1);
      feed4(-1, -1, -1, -2, 0);
      idle(2);
      chk("t2_sum_neg", obs, 'h3FFFB);

      // extremes
      step(0, 0, 0, 0, 1);
      feed4(32767, 32767, 32767, 32767, 0);
      idle(2);
      chk("t3_max", obs, 'h1FFFC);
      step(0, 0, 0, 0, 1);
      feed4(-32768, -32768, -32768, -32768, 0);
      idle(2);
      chk("t3_min", obs, 'h20000);
      feed4(-32768, -32768, -32768, -32768, 1);
      idle(2);
      chk("t3_min_avg", obs, (-32768) & msk());

      // gaps in the input stream
      step(0, 0, 0, 0, 1);
      step(1, 5, 0, 0, 0);
      step(1, 6, 0, 0, 0);
      step(1, 7, 0, 0, 0);
      idle(3);
      step(1, 8, 0, 0, 0);
      idle(3);
      chk("t4_gap", obs, 26);

      // clear, then reset, one cycle after a full-window accept
      for (int k = 0; k < 2; k++) begin
         step(0, 0, 0, 0, 1);
         feed4(1, 2, 3, 4, 0);
         step(1, 9, 0, k == 0, k == 1);
         feed4(10, 20, 30, 40, 0);
         idle(2);
         chk(k == 0 ? "t5_clear" : "t5_reset", obs, 100);
      end

      // randomized stream on the 8-tap instance
      sel = 1; T = 8; LGv = 3; OWv = 27;
      step(0, 0, 0, 0, 1);
      n = 0;
      it = 0;
      while (n < 200 && it < 2000) begin
         v = ($urandom_range(0, 3) != 0);
         r = int'($urandom_range(0, 16777215));
         d = (r >= 8388608) ? longint'(r) - 16777216 : longint'(r);
         c = ($urandom_range(0, 99) == 0);
         step(v, d, $urandom_range(0, 1) == 1, c, 0);
         if (v && !c) n++;
         it++;
      end
      chk("t6_count", longint'(n), 200);
      idle(5);
      chk("t6_drained", longint'(pend.num()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
